// File: rtl/des_pkg.sv
// Shared constants for the DES S-box bank: the eight standard S-boxes,
// re-ordered so that a box is indexed directly by its raw 6-bit input.
package des_pkg;

  localparam int SBOX_IN_W   = 6;
  localparam int SBOX_OUT_W  = 4;
  localparam int NUM_DES_BOX = 8;

  typedef logic [63:0][3:0]       sbox_tbl_t;
  typedef logic [7:0][63:0][3:0]  sbox_bank_t;

  // Standard DES S1..S8 in the usual [row][col] published form.
  localparam logic [3:0] DES_STD [8][4][16] = '{
    '{'{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7},
      '{ 0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8},
      '{ 4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0},
      '{15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13}},
    '{'{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10},
      '{ 3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5},
      '{ 0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15},
      '{13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9}},
    '{'{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8},
      '{13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1},
      '{13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7},
      '{ 1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12}},
    '{'{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15},
      '{13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9},
      '{10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4},
      '{ 3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14}},
    '{'{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
      '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
      '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
      '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}},
    '{'{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11},
      '{10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8},
      '{ 9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6},
      '{ 4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13}},
    '{'{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1},
      '{13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6},
      '{ 1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2},
      '{ 6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12}},
    '{'{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7},
      '{ 1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2},
      '{ 7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8},
      '{ 2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}}
  };

  // Raw index i maps to row {i[5],i[0]} and column i[4:1].
  function automatic sbox_bank_t build_raw_order();
    sbox_bank_t r;
    logic [5:0] ix;
    r = '0;
    for (int b = 0; b < NUM_DES_BOX; b++) begin
      for (int i = 0; i < 64; i++) begin
        ix = 6'(i);
        r[3'(b)][ix] = DES_STD[3'(b)][{ix[5], ix[0]}][ix[4:1]];
      end
    end
    return r;
  endfunction

  localparam sbox_bank_t DES_SBOX = build_raw_order();

  function automatic logic [3:0] des_entry(input int box, input logic [5:0] idx);
    return DES_SBOX[3'(box)][idx];
  endfunction

endpackage

// File: rtl/des_sbox_table.sv
// One rewritable 64x4 S-box table; resets/restores to standard box BOX_ID.
module des_sbox_table import des_pkg::*; #(
  parameter int BOX_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  restore_i,
  input  logic [SBOX_IN_W-1:0]  waddr_i,
  input  logic [SBOX_OUT_W-1:0] wdata_i,
  input  logic [SBOX_IN_W-1:0]  raddr_i,
  output logic [SBOX_OUT_W-1:0] rdata_o
);

  logic [SBOX_OUT_W-1:0] mem_q [64];

  // Table storage: restore beats a write landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= des_entry(BOX_ID, 6'(i));
    end else if (restore_i) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= des_entry(BOX_ID, 6'(i));
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/des_sbox_bank.sv
// Bank of NUM_BOX S-box lookups feeding a PIPE_STAGES-deep valid/ready pipeline.
module des_sbox_bank import des_pkg::*; #(
  parameter int NUM_BOX     = 8,
  parameter int PIPE_STAGES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SBOX_IN_W*NUM_BOX-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SBOX_OUT_W*NUM_BOX-1:0] out_data,
  input  logic                          tbl_we,
  input  logic [2:0]                    tbl_box,
  input  logic [5:0]                    tbl_addr,
  input  logic [3:0]                    tbl_wdata,
  input  logic                          tbl_restore,
  output logic                          tbl_err
);

  localparam int DW = SBOX_OUT_W * NUM_BOX;

  logic [DW-1:0]          lookup;
  logic                   box_ok;
  logic                   tbl_err_q;
  logic [PIPE_STAGES-1:0] v_q, v_d, load, src_v;
  logic [DW-1:0]          d_q   [PIPE_STAGES];
  logic [DW-1:0]          d_d   [PIPE_STAGES];
  logic [DW-1:0]          src_d [PIPE_STAGES];

  assign box_ok = int'(tbl_box) < NUM_BOX;

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
    des_sbox_table #(.BOX_ID(k)) u_tbl (
      .clk       (clk),
      .rst       (rst),
      .we_i      (tbl_we && (tbl_box == 3'(k))),
      .restore_i (tbl_restore),
      .waddr_i   (tbl_addr),
      .wdata_i   (tbl_wdata),
      .raddr_i   (in_data[SBOX_IN_W*(NUM_BOX-k)-1 -: SBOX_IN_W]),
      .rdata_o   (lookup[SBOX_OUT_W*(NUM_BOX-k)-1 -: SBOX_OUT_W])
    );
  end

  // Stage 0 is fed by the lookup, later stages by their predecessor.
  for (genvar n = 0; n < PIPE_STAGES; n++) begin : g_src
    if (n == 0) begin : g_first
      assign src_v[n] = in_valid;
      assign src_d[n] = lookup;
    end else begin : g_next
      assign src_v[n] = v_q[n-1];
      assign src_d[n] = d_q[n-1];
    end
  end

  // A stage may load if it, or any stage downstream, has a hole, or the output drains.
  always_comb begin
    for (int n = 0; n < PIPE_STAGES; n++) begin
      load[n] = out_ready;
      for (int m = n; m < PIPE_STAGES; m++) begin
        if (!v_q[m]) load[n] = 1'b1;
      end
    end
  end

  // Next-state of each stage; data only moves with a valid beat so held output stays put.
  always_comb begin
    for (int n = 0; n < PIPE_STAGES; n++) begin
      v_d[n] = v_q[n];
      d_d[n] = d_q[n];
      if (load[n]) begin
        v_d[n] = src_v[n];
        if (src_v[n]) d_d[n] = src_d[n];
      end
    end
  end

  // Pipeline registers and sticky bad-box flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      tbl_err_q <= 1'b0;
      for (int n = 0; n < PIPE_STAGES; n++) d_q[n] <= '0;
    end else begin
      v_q       <= v_d;
      tbl_err_q <= tbl_err_q | (tbl_we && !box_ok);
      for (int n = 0; n < PIPE_STAGES; n++) d_q[n] <= d_d[n];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[PIPE_STAGES-1];
  assign out_data  = d_q[PIPE_STAGES-1];
  assign tbl_err   = tbl_err_q;

endmodule
